// File: rtl/hood_pkg.sv
// Shared encodings for the range-hood display path: modes, glyph codes,
// digit positions and the per-field decimal split helpers.
package hood_pkg;

  localparam logic [2:0] MODE_STANDBY   = 3'd0;
  localparam logic [2:0] MODE_G1        = 3'd1;
  localparam logic [2:0] MODE_G2        = 3'd2;
  localparam logic [2:0] MODE_HURRICANE = 3'd3;

  // Glyph codes 0..9 are the numerals themselves.
  localparam logic [3:0] GLYPH_0     = 4'd0;
  localparam logic [3:0] GLYPH_9     = 4'd9;
  localparam logic [3:0] GLYPH_BLANK = 4'd10;
  localparam logic [3:0] GLYPH_DASH  = 4'd11;

  localparam logic [2:0] DIG_MODE   = 3'd7;
  localparam logic [2:0] DIG_GAP    = 3'd6;
  localparam logic [2:0] DIG_H_TENS = 3'd5;
  localparam logic [2:0] DIG_H_ONES = 3'd4;
  localparam logic [2:0] DIG_M_TENS = 3'd3;
  localparam logic [2:0] DIG_M_ONES = 3'd2;
  localparam logic [2:0] DIG_S_TENS = 3'd1;
  localparam logic [2:0] DIG_S_ONES = 3'd0;
  localparam logic [2:0] DIG_LAST   = 3'd7;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [3:0] tens_of(input logic [6:0] v);
    logic [6:0] s;
    s = sat99(v);
    return 4'(s / 7'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [6:0] v);
    logic [6:0] s;
    s = sat99(v);
    return 4'(s % 7'd10);
  endfunction

endpackage

// File: rtl/hood_seg_decode.sv
// Glyph code to seven-segment pattern {g,f,e,d,c,b,a}, active-high.
module hood_seg_decode
  import hood_pkg::*;
(
  input  logic [3:0] glyph,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (glyph)
      4'd0:       seg = 7'h3F;
      4'd1:       seg = 7'h06;
      4'd2:       seg = 7'h5B;
      4'd3:       seg = 7'h4F;
      4'd4:       seg = 7'h66;
      4'd5:       seg = 7'h6D;
      4'd6:       seg = 7'h7D;
      4'd7:       seg = 7'h07;
      4'd8:       seg = 7'h7F;
      4'd9:       seg = 7'h6F;
      GLYPH_DASH: seg = 7'h40;
      default:    seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/hood_display_scan.sv
// 8-digit multiplexed display scanner for the hood: mode, HH MM SS work
// time or hurricane countdown, with inputs snapshotted once per frame.
module hood_display_scan
  import hood_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_on,
  input  logic [2:0] mode_state,
  input  logic [6:0] cum_h,
  input  logic [5:0] cum_m,
  input  logic [5:0] cum_s,
  input  logic [6:0] cd_s,
  output logic [7:0] seg_en,
  output logic [7:0] seg_out
);

  localparam int DIV  = CLK_HZ / SCAN_HZ;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BDIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW   = (BDIV > 1) ? $clog2(BDIV) : 1;

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic [2:0]    dig_idx;
  logic [2:0]    next_idx;
  logic          wrap;

  logic       snap_power;
  logic [2:0] snap_mode;
  logic [6:0] snap_h;
  logic [5:0] snap_m;
  logic [5:0] snap_s;
  logic [6:0] snap_cd;

  logic       src_power;
  logic [2:0] src_mode;
  logic [6:0] src_h;
  logic [5:0] src_m;
  logic [5:0] src_s;
  logic [6:0] src_cd;

  logic       hurricane;
  logic       blink_active;
  logic [3:0] glyph;
  logic       dp;
  logic [6:0] seg7;

  assign tick     = (tick_cnt == CW'(DIV - 1));
  assign next_idx = dig_idx + 3'd1;
  assign wrap     = tick && (dig_idx == DIG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      dig_idx  <= 3'd0;
    end else if (tick) begin
      tick_cnt <= '0;
      dig_idx  <= next_idx;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BW'(BDIV - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_power <= 1'b0;
      snap_mode  <= 3'd0;
      snap_h     <= 7'd0;
      snap_m     <= 6'd0;
      snap_s     <= 6'd0;
      snap_cd    <= 7'd0;
    end else if (wrap) begin
      snap_power <= power_on;
      snap_mode  <= mode_state;
      snap_h     <= cum_h;
      snap_m     <= cum_m;
      snap_s     <= cum_s;
      snap_cd    <= cd_s;
    end
  end

  // Digit 0 of a new frame is rendered on the capturing tick, so it must
  // see the values being captured rather than the stale snapshot.
  always_comb begin
    src_power = wrap ? power_on   : snap_power;
    src_mode  = wrap ? mode_state : snap_mode;
    src_h     = wrap ? cum_h      : snap_h;
    src_m     = wrap ? cum_m      : snap_m;
    src_s     = wrap ? cum_s      : snap_s;
    src_cd    = wrap ? cd_s       : snap_cd;
  end

  always_comb begin
    glyph        = GLYPH_BLANK;
    dp           = 1'b0;
    hurricane    = (src_mode == MODE_HURRICANE);
    blink_active = hurricane && (src_cd <= 7'd5);
    case (next_idx)
      DIG_MODE:   glyph = (src_mode <= MODE_HURRICANE) ? {1'b0, src_mode} : GLYPH_DASH;
      DIG_GAP:    glyph = GLYPH_BLANK;
      DIG_H_TENS: if (!hurricane) glyph = tens_of(src_h);
      DIG_H_ONES: if (!hurricane) begin
                    glyph = ones_of(src_h);
                    dp    = 1'b1;
                  end
      DIG_M_TENS: if (!hurricane) glyph = tens_of({1'b0, src_m});
      DIG_M_ONES: if (!hurricane) begin
                    glyph = ones_of({1'b0, src_m});
                    dp    = 1'b1;
                  end
      DIG_S_TENS: glyph = hurricane ? tens_of(src_cd) : tens_of({1'b0, src_s});
      DIG_S_ONES: glyph = hurricane ? ones_of(src_cd) : ones_of({1'b0, src_s});
      default:    glyph = GLYPH_BLANK;
    endcase
    if (blink_active && !blink_on &&
        (next_idx == DIG_S_TENS || next_idx == DIG_S_ONES)) begin
      glyph = GLYPH_BLANK;
    end
  end

  hood_seg_decode u_dec (
    .glyph (glyph),
    .seg   (seg7)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_en  <= 8'h00;
      seg_out <= 8'h00;
    end else if (tick) begin
      seg_en  <= src_power ? (8'd1 << next_idx) : 8'h00;
      seg_out <= src_power ? {dp, seg7} : 8'h00;
    end
  end

endmodule

// File: tb/tb_hood_display_scan.sv
// Bench for hood_display_scan: frame-level reference model checked every
// cycle, plus literal per-digit expectations for the directed scenarios.
module tb_hood_display_scan;

  localparam int CLK_HZ   = 1000;
  localparam int SCAN_HZ  = 100;
  localparam int BLINK_HZ = 50;
  localparam int DIV      = CLK_HZ / SCAN_HZ;
  localparam int BD       = CLK_HZ / (2 * BLINK_HZ);

  logic       clk;
  logic       rst_n;
  logic       power_on;
  logic [2:0] mode_state;
  logic [6:0] cum_h;
  logic [5:0] cum_m;
  logic [5:0] cum_s;
  logic [6:0] cd_s;
  logic [7:0] seg_en;
  logic [7:0] seg_out;

  int total = 0;
  int bad   = 0;

  hood_display_scan #(
    .CLK_HZ   (CLK_HZ),
    .SCAN_HZ  (SCAN_HZ),
    .BLINK_HZ (BLINK_HZ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .power_on   (power_on),
    .mode_state (mode_state),
    .cum_h      (cum_h),
    .cum_m      (cum_m),
    .cum_s      (cum_s),
    .cd_s       (cd_s),
    .seg_en     (seg_en),
    .seg_out    (seg_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: frame-level view of the display
  logic [15:0] exp_q[$];
  logic [15:0] cur_exp;
  int unsigned n_edge;
  int unsigned t_idx;
  bit          m_pow;
  int          m_mode, m_h, m_m, m_s, m_cd;

  function automatic logic [6:0] seg_of(input int g);
    case (g)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  11: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  function automatic logic [15:0] model_word(input int d, input bit ph_on);
    int g;
    bit dp;
    bit hur;
    if (!m_pow) return 16'h0000;
    hur = (m_mode == 3);
    g   = -1;
    dp  = 1'b0;
    case (d)
      7: g = (m_mode <= 3) ? m_mode : 11;
      5: if (!hur) g = sat(m_h) / 10;
      4: if (!hur) begin g = sat(m_h) % 10; dp = 1'b1; end
      3: if (!hur) g = sat(m_m) / 10;
      2: if (!hur) begin g = sat(m_m) % 10; dp = 1'b1; end
      1: g = hur ? sat(m_cd) / 10 : sat(m_s) / 10;
      0: g = hur ? sat(m_cd) % 10 : sat(m_s) % 10;
      default: g = -1;
    endcase
    if (hur && m_cd <= 5 && !ph_on && d <= 1) g = -1;
    return {8'(1 << d), dp, seg_of(g)};
  endfunction

  // scoreboard: tick-by-tick expectations, compared every cycle
  always @(posedge clk) begin
    if (!rst_n) begin
      n_edge = 0;
      m_pow  = 1'b0;
      m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_cd = 0;
      exp_q.delete();
      cur_exp = 16'h0000;
    end else begin
      n_edge++;
      if (n_edge % DIV == 0) begin
        t_idx = n_edge / DIV;
        if (t_idx % 8 == 0) begin
          m_pow  = power_on;
          m_mode = int'(mode_state);
          m_h    = int'(cum_h);
          m_m    = int'(cum_m);
          m_s    = int'(cum_s);
          m_cd   = int'(cd_s);
        end
        exp_q.push_back(model_word(int'(t_idx % 8), ((n_edge - 1) / BD) % 2 == 0));
      end
    end
    #1;
    if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
    check("scan", {16'h0, seg_en, seg_out}, {16'h0, cur_exp});
    check("onehot", 32'($countones(seg_en) <= 1), 32'd1);
  end

  // drivers
  task automatic set_inputs(input bit p, input int mode, input int h, input int m,
                            input int s, input int cd);
    @(negedge clk);
    power_on   = p;
    mode_state = 3'(mode);
    cum_h      = 7'(h);
    cum_m      = 6'(m);
    cum_s      = 6'(s);
    cd_s       = 7'(cd);
  endtask

  task automatic wait_digit(input logic [7:0] en, input string name);
    int k;
    k = 0;
    while (seg_en == en && k < 200) begin @(posedge clk); #2; k++; end
    while (seg_en != en && k < 200) begin @(posedge clk); #2; k++; end
    check({name, "_en"}, {24'h0, seg_en}, {24'h0, en});
  endtask

  task automatic check_frame(input logic [63:0] f, input string name);
    wait_digit(8'h01, name);
    check(name, {24'h0, seg_out}, {24'h0, f[7:0]});
    for (int d = 1; d < 8; d++) begin
      wait_digit(8'(1 << d), name);
      check(name, {24'h0, seg_out}, {24'h0, f[d*8 +: 8]});
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    power_on   = 1'b1;
    mode_state = 3'd0;
    cum_h      = 7'd0;
    cum_m      = 6'd0;
    cum_s      = 6'd0;
    cd_s       = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_en",  {24'h0, seg_en},  32'h0);
    check("reset_out", {24'h0, seg_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // blank until the first frame boundary, then a 10-cycle-per-digit walk
    repeat (75) @(negedge clk);
    check("pre_frame_blank", {24'h0, seg_en}, 32'h0);
    wait_digit(8'h01, "first_digit");
    check("first_digit_out", {24'h0, seg_out}, 32'h3F);
    repeat (120) @(negedge clk);

    set_inputs(1, 1, 12, 34, 56, 0);
    check_frame(64'h06_00_06_DB_4F_E6_6D_7D, "time_123456");

    set_inputs(1, 3, 12, 34, 56, 42);
    check_frame(64'h4F_00_00_00_00_00_66_5B, "cd_42");
    check_frame(64'h4F_00_00_00_00_00_66_5B, "cd_42_again");

    set_inputs(1, 3, 12, 34, 56, 5);
    check_frame(64'h4F_00_00_00_00_00_3F_00, "cd_05_blink");
    repeat (200) @(negedge clk);

    // change seconds while digit 3 is lit
    set_inputs(1, 1, 12, 34, 56, 0);
    check_frame(64'h06_00_06_DB_4F_E6_6D_7D, "pre_change");
    wait_digit(8'h08, "mid_frame");
    set_inputs(1, 1, 12, 34, 11, 0);
    wait_digit(8'h01, "after_change");
    check("after_change_out", {24'h0, seg_out}, 32'h06);

    set_inputs(1, 6, 120, 34, 56, 0);
    check_frame(64'h40_00_6F_EF_4F_E6_6D_7D, "sat_dash");

    // power drop mid-frame
    wait_digit(8'h08, "pwr_mid");
    set_inputs(0, 6, 120, 34, 56, 0);
    repeat (20) @(negedge clk);
    check("pwr_still_on", 32'(seg_en != 8'h00), 32'd1);
    repeat (80) @(negedge clk);
    check("pwr_off_en", {24'h0, seg_en}, 32'h0);

    for (int i = 0; i < 40; i++) begin
      set_inputs($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 127),
                 $urandom_range(0, 63), $urandom_range(0, 63),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 127));
      repeat ($urandom_range(5, 120)) @(negedge clk);
    end

    // asynchronous reset away from any clock edge
    set_inputs(1, 2, 7, 8, 9, 0);
    repeat (100) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_en",  {24'h0, seg_en},  32'h0);
    check("async_rst_out", {24'h0, seg_out}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (75) @(negedge clk);
    check("post_rst_blank", {24'h0, seg_en}, 32'h0);
    wait_digit(8'h01, "post_rst_digit0");
    check("post_rst_out", {24'h0, seg_out}, 32'h6F);
    repeat (100) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hood_display_scan.md
# hood_display_scan

Display reader for the range-hood controller. It consumes the mode state, cumulative work time and hurricane countdown that the hood control path produces. It renders them on the board's 8-digit multiplexed seven-segment display. Inputs are snapshotted once per scan frame so a frame never shows a half-updated time.

## Interface
- `CLK_HZ`, default 100_000_000, system clock frequency.
- `SCAN_HZ`, default 1000, digit-advance rate; a full frame takes 8 ticks.
- `BLINK_HZ`, default 2, countdown-warning blink rate.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `power_on`  in  1  hood powered; 0 blanks the display.
- `mode_state`  in  3  0 standby, 1 gear 1, 2 gear 2, 3 hurricane.
- `cum_h`  in  7  cumulative hours, 0..99.
- `cum_m`  in  6  cumulative minutes, 0..59.
- `cum_s`  in  6  cumulative seconds, 0..59.
- `cd_s`  in  7  hurricane countdown seconds, 0..99.
- `seg_en`  out  8  digit enables, one-hot, active-high; bit 7 is the leftmost digit.
- `seg_out`  out  8  segments {dp,g,f,e,d,c,b,a}, active-high.

## Operation
- Tick generator: a counter of width clog2(DIV), where DIV = CLK_HZ/SCAN_HZ. It counts 0..DIV-1. The tick fires on the cycle the counter equals DIV-1, and the counter then wraps to 0.
- Digit index: 3 bits. It increments on each tick and wraps from 7 to 0.
- Snapshot: on the tick where the index wraps 7→0, register all data inputs.
  - This includes `power_on`, so power changes take effect at frame boundaries.
  - Digits 7..0 of the new frame all use this snapshot.
- Digit map:
  - Digit 7 shows the mode as a numeral 0..3. A mode value above 3 shows '-' (segment g only).
  - Digit 6 is always blank.
  - Digits 5..0, when mode is not 3: HH MM SS of the cumulative time.
    - The decimal point is lit on digits 4 and 2 as separators.
  - Digits 5..0, when mode is 3: digits 5..2 are blank, and digits 1..0 show `cd_s`.
- Per-field conversion: tens = v/10 and ones = v%10, computed for each field separately.
  - Any value above 99 saturates to 99 before conversion.
  - Minutes and seconds above 59 are displayed as given; there is no correction.
- Blink: a phase flop toggles every CLK_HZ/(2·BLINK_HZ) cycles and resets to the "on" phase.
  - Blink applies when mode is 3 and the snapshot `cd_s` is 5 or less.
  - During blink, digits 1..0 are blanked (segments 0) whenever the phase is "off".
- Power off (snapshot `power_on` = 0): `seg_en` is all zeros. The scan counters keep running.

## Timing
- Reset values:
  - `seg_en` = 8'h00 and `seg_out` = 8'h00.
  - Digit index = 0 and tick counter = 0.
  - Snapshot registers = 0, including snapshot power, so the display stays blank until the first frame boundary.
  - Blink phase = on.
- `seg_en` and `seg_out` are registered. They change exactly 1 cycle after a tick and stay constant in between.
  - `seg_en` is never multi-hot.
  - `seg_en` and `seg_out` always update in the same cycle.
- Input-to-display latency:
  - Best case 1 cycle after the frame-boundary tick.
  - Worst case 8·DIV+1 cycles.
- Simultaneous events:
  - Snapshot capture and the digit-0 output update occur on the same tick.
  - Digit 0 of the new frame uses the new snapshot.
- An asynchronous reset mid-frame blanks the outputs immediately. Scanning restarts at digit 0.

## Structure
- Shared package `hood_pkg`:
  - Mode encodings (MODE_STANDBY=0, MODE_G1=1, MODE_G2=2, MODE_HURRICANE=3).
  - Glyph constants: digits 0-9, BLANK, DASH.
  - Digit-position constants.
- Sub-module `hood_seg_decode`: combinational, 4-bit glyph code → 7-segment pattern. Codes 10 = blank, 11 = dash.
- Top file contains the tick/blink counters, snapshot registers, digit mux and output registers.

## Test plan
All scenarios use CLK_HZ=1000, SCAN_HZ=100 (DIV=10) and BLINK_HZ=50 (toggle every 10 cycles).
- Reset, then hold `power_on`=1 for 200 cycles.
  - Required: outputs are 0 until the first 7→0 wrap.
  - Then `seg_en` walks 01,02,…,80 with each value lasting 10 cycles, and is always one-hot.
- Inputs: mode=1, cum 12:34:56.
  - Required: digit 7 shows '1'; digit 6 is blank; digits 5..0 show "123456"; dp is set on digits 4 and 2 only.
- Inputs: mode=3, `cd_s`=42.
  - Required: digits 5..2 are blank, digits 1..0 show "42", and there is no blinking.
  - Then set `cd_s`=5: digits 1..0 alternate between "05" and blank, following the blink phase.
- Change `cum_s` mid-frame, at digit 3.
  - Required: the remainder of the frame shows the old value; the new value appears from the next frame's digit 0.
- Inputs: `cum_h`=120 and mode=6.
  - Required: hours show "99"; digit 7 shows dash (8'h40).
- Drop `power_on` mid-frame.
  - Required: `seg_en`=0 from the next frame boundary.
  - Assert `rst_n`=0 at an arbitrary cycle: outputs go to 0 immediately, without waiting for a clock edge.
